fetch_redirect_unit: RTL

FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

---
 rtl/fetch_redirect_unit_pkg.sv | 16 +
 rtl/fetch_redirect_unit_target_mux.sv | 23 ++
 rtl/fetch_redirect_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared pipeline constants for the fetch/redirect stage: FSM encoding, reset
// vector, NOP word and the branch-offset helper.
package fetch_redirect_unit_pkg;

    localparam logic        STATE_RUN       = 1'b0;
    localparam logic        STATE_BUBBLE    = 1'b1;
    localparam logic [31:0] RESET_VECTOR    = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
    localparam logic [15:0] FLUSH_COUNT_MAX = 16'hFFFF;

    // Sign-extended word offset of a 16-bit branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_redirect_unit_target_mux.sv
// Redirect target selection for the fetch stage, priority jr > bne > jump.
module redirect_target_mux
    import fetch_redirect_unit_pkg::*;
(
    input  logic        sel_jr,
    input  logic        sel_bne,
    input  logic [31:0] rs_value,
    input  logic [31:0] pc4,
    input  logic [25:0] instr_index,
    output logic [31:0] target
);

    always_comb begin
        if (sel_jr) begin
            target = rs_value;
        end else if (sel_bne) begin
            target = pc4 + branch_offset(instr_index[15:0]);
        end else begin
            target = {pc4[31:28], instr_index, 2'b00};
        end
    end

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC register, IF/ID pipeline register and redirect/flush control with a
// one-cycle bubble after every taken redirect.
module fetch_redirect_unit
    import fetch_redirect_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] if_instr,
    input  logic        id_jump,
    input  logic        id_bne,
    input  logic        id_jr,
    input  logic        id_equal,
    input  logic [31:0] id_rs_value,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        jump,
    output logic        bne,
    output logic        jr,
    output logic [15:0] flush_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        state_q, state_d;
    logic [15:0] flush_count_q, flush_count_d;

    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] target;

    // A flushed IF/ID is invalid, so redirects cannot issue from BUBBLE.
    assign jump     = id_jump & ifid_valid_q;
    assign bne      = id_bne & ~id_equal & ifid_valid_q;
    assign jr       = id_jr & ifid_valid_q;
    assign redirect = jump | bne | jr;
    assign pc_plus4 = pc_q + 32'd4;

    redirect_target_mux u_target_mux (
        .sel_jr      (jr),
        .sel_bne     (bne),
        .rs_value    (id_rs_value),
        .pc4         (ifid_pc4_q),
        .instr_index (ifid_instr_q[25:0]),
        .target      (target)
    );

    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        if (redirect) begin
            pc_d         = target;
            ifid_instr_d = NOP_WORD;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d         = pc_plus4;
            ifid_instr_d = if_instr;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d = STATE_RUN;
        case (state_q)
            STATE_RUN:    state_d = redirect ? STATE_BUBBLE : STATE_RUN;
            STATE_BUBBLE: state_d = STATE_RUN;
            default:      state_d = STATE_RUN;
        endcase
    end

    always_comb begin
        flush_count_d = flush_count_q;
        if (redirect && (flush_count_q != FLUSH_COUNT_MAX)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_VECTOR;
            ifid_instr_q  <= NOP_WORD;
            ifid_pc4_q    <= '0;
            ifid_valid_q  <= 1'b0;
            state_q       <= STATE_RUN;
            flush_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            ifid_instr_q  <= ifid_instr_d;
            ifid_pc4_q    <= ifid_pc4_d;
            ifid_valid_q  <= ifid_valid_d;
            state_q       <= state_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign pc          = pc_q;
    assign ifid_instr  = ifid_instr_q;
    assign ifid_pc4    = ifid_pc4_q;
    assign ifid_valid  = ifid_valid_q;
    assign flush_count = flush_count_q;

endmodule
